// File: rtl/os_lane_aligner.sv
// Ordered-set lane aligner: hunts lane-0 ordered-set starts (8b/10b COM or 128b/130b
//   block header) and captures every active lane in lockstep into a small output FIFO.
// Latency: entry visible on os_valid the cycle after its last symbol; os_ready backpressure
//   holds the head entry stable, a push into a full FIFO without a pop is dropped (overflow).
//
// Ports: clk/reset (async active-low); mode 0=8b/10b 1=128b/130b; active_lanes lane count;
//   data_in/data_valid/block_start/sync_hdr symbol input; os_valid/os_ready/os_data/os_type/
//   os_len ordered-set output; overflow and os_err are single-cycle status pulses.

module os_lane_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         empty, do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = rd_rdy && !empty;
      // a pop frees the slot this same cycle, so push+pop on a full FIFO succeeds
      do_push  = wr_vld && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      rd_vld   = !empty;
      rd_dat   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
   end
endmodule

module os_lane_aligner #(
   parameter int LANES = 4,
   parameter int SYMS  = 2,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [4:0]              active_lanes,
   input  logic [LANES*SYMS*8-1:0] data_in,
   input  logic                    data_valid,
   input  logic                    block_start,
   input  logic [1:0]              sync_hdr,
   input  logic                    os_ready,
   output logic                    os_valid,
   output logic [LANES*128-1:0]    os_data,
   output logic [2:0]              os_type,
   output logic [4:0]              os_len,
   output logic                    overflow,
   output logic                    os_err
);
   localparam int         EW    = LANES*128 + 8;
   localparam logic [7:0] COM   = 8'hBC;
   localparam logic [2:0] EIEOS = 3'd4;

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [2:0]           type_q, type_d;
   logic [4:0]           len_q, len_d;
   logic [LANES*128-1:0] buf_q, buf_d;
   logic                 mode_q, mode_d;
   logic [4:0]           lanes_q, lanes_d;
   logic                 err_q, err_d;
   logic                 ovf_q, ovf_d;
   logic                 push_vld, take, fifo_full;
   logic [EW-1:0]        push_dat, fifo_rd_dat;
   logic [7:0]           sym;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      type_d   = type_q;
      len_d    = len_q;
      buf_d    = buf_q;
      mode_d   = mode;
      lanes_d  = active_lanes;
      err_d    = 1'b0;
      push_vld = 1'b0;
      push_dat = '0;
      sym      = '0;
      take     = 1'b0;

      // reconfiguration throws away any partial set; FIFO contents are untouched
      if ((mode != mode_q) || (active_lanes != lanes_q)) begin
         state_d = HUNT;
         cnt_d   = '0;
      end

      if (data_valid) begin
         // symbols walked in arrival order so a set can finish and the next start mid-cycle
         for (int k = 0; k < SYMS; k++) begin
            sym  = data_in[k*8 +: 8];
            take = 1'b0;
            if (state_d == HUNT) begin
               if (!mode) begin
                  if (sym == COM) begin
                     state_d = COLLECT;
                     cnt_d   = '0;
                     buf_d   = '0;
                     type_d  = 3'd0;
                     len_d   = 5'd16;
                     take    = 1'b1;
                  end
               end else if ((k == 0) && block_start) begin
                  if (sync_hdr == 2'b01) begin
                     take  = 1'b1;
                     len_d = 5'd16;
                     case (sym)
                        8'h1E:   type_d = 3'd0;
                        8'h2D:   type_d = 3'd1;
                        8'hAA:   type_d = 3'd2;
                        8'h66:   type_d = 3'd3;
                        8'h00:   type_d = 3'd4;
                        default: begin take = 1'b0; err_d = 1'b1; end
                     endcase
                     if (take) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                        buf_d   = '0;
                     end
                  end else if (sync_hdr != 2'b10) begin
                     err_d = 1'b1;
                  end
               end
            end else if (!mode && (cnt_d == 5'd1)) begin
               // symbol 1 after COM identifies the set and its length
               take = 1'b1;
               case (sym)
                  8'h4A:   begin type_d = 3'd0; len_d = 5'd16; end
                  8'h45:   begin type_d = 3'd1; len_d = 5'd16; end
                  8'h1C:   begin type_d = 3'd2; len_d = 5'd4;  end
                  8'h7C:   begin type_d = 3'd3; len_d = 5'd4;  end
                  8'hFC:   begin type_d = 3'd4; len_d = 5'd16; end
                  8'h3C:   begin type_d = 3'd5; len_d = 5'd4;  end
                  default: begin take = 1'b0; err_d = 1'b1; state_d = HUNT; cnt_d = '0; end
               endcase
            end else if (!mode && (sym == COM) && (len_d == 5'd16) && (type_d != EIEOS)) begin
               // COM inside a long set: the set was cut short, restart on this COM
               err_d  = 1'b1;
               cnt_d  = '0;
               buf_d  = '0;
               type_d = 3'd0;
               take   = 1'b1;
            end else begin
               take = 1'b1;
            end

            if (take) begin
               for (int l = 0; l < LANES; l++) begin
                  if (l < int'(active_lanes))
                     buf_d[l*128 + int'(cnt_d)*8 +: 8] = data_in[(l*SYMS+k)*8 +: 8];
               end
               cnt_d = cnt_d + 5'd1;
               if (cnt_d == len_d) begin
                  push_vld = 1'b1;
                  push_dat = {type_d, len_d, buf_d};
                  state_d  = HUNT;
                  cnt_d    = '0;
               end
            end
         end
      end

      // a full FIFO is never empty, so os_ready alone tells whether a pop happens
      ovf_d = push_vld && fifo_full && !os_ready;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         type_q  <= '0;
         len_q   <= '0;
         buf_q   <= '0;
         mode_q  <= 1'b0;
         lanes_q <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         len_q   <= len_d;
         buf_q   <= buf_d;
         mode_q  <= mode_d;
         lanes_q <= lanes_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   os_lane_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (push_vld),
      .wr_dat (push_dat),
      .rd_rdy (os_ready),
      .rd_vld (os_valid),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full)
   );

   assign os_type  = fifo_rd_dat[EW-1 -: 3];
   assign os_len   = fifo_rd_dat[EW-4 -: 5];
   assign os_data  = fifo_rd_dat[LANES*128-1:0];
   assign os_err   = err_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_os_lane_aligner.sv
module tb_os_lane_aligner;
   localparam int LANES = 4;
   localparam int SYMS  = 2;
   localparam int DEPTH = 4;
   localparam int DW    = LANES*SYMS*8;

   logic                 clk;
   logic                 reset;
   logic                 mode;
   logic [4:0]           active_lanes;
   logic [DW-1:0]        data_in;
   logic                 data_valid;
   logic                 block_start;
   logic [1:0]           sync_hdr;
   logic                 os_ready;
   logic                 os_valid;
   logic [LANES*128-1:0] os_data;
   logic [2:0]           os_type;
   logic [4:0]           os_len;
   logic                 overflow;
   logic                 os_err;

   os_lane_aligner #(.LANES(LANES), .SYMS(SYMS), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .mode(mode), .active_lanes(active_lanes),
      .data_in(data_in), .data_valid(data_valid), .block_start(block_start),
      .sync_hdr(sync_hdr), .os_ready(os_ready), .os_valid(os_valid),
      .os_data(os_data), .os_type(os_type), .os_len(os_len),
      .overflow(overflow), .os_err(os_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]           t;
      logic [4:0]           len;
      logic [LANES*128-1:0] d;
   } ent_t;

   ent_t                 exp_q[$];
   logic [LANES*8-1:0]   strm[$];   // one element = one symbol time across all lanes
   logic [1:0]           hdr_q[$];
   int checks = 0, fails = 0;
   int err_seen = 0, err_exp = 0, ovf_seen = 0, ovf_exp = 0;

   task automatic chk(input string nm, input logic [LANES*128-1:0] act, input logic [LANES*128-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic                 hold = 1'b0;
   logic [LANES*128-1:0] hd;
   logic [2:0]           ht;
   logic [4:0]           hl;

   always @(negedge clk) begin
      ent_t e;
      if (!reset) begin
         hold = 1'b0;
      end else begin
         if (os_err) err_seen++;
         if (overflow) ovf_seen++;
         if (hold) begin
            chk("held os_valid", os_valid, 1);
            chk("held os_data", os_data, hd);
            chk("held os_type", os_type, ht);
            chk("held os_len", os_len, hl);
         end
         if (os_valid && os_ready) begin
            if (exp_q.size() == 0) chk("unexpected entry", os_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("os_type", os_type, e.t);
               chk("os_len", os_len, e.len);
               chk("os_data", os_data, e.d);
            end
         end
         hold = os_valid && !os_ready;
         hd = os_data; ht = os_type; hl = os_len;
      end
   end

   // ---------------- reference model ----------------
   task automatic dec0(input logic [7:0] b, output bit ok, output logic [2:0] t, output int len);
      ok = 1'b1; t = 3'd0; len = 16;
      case (b)
         8'h4A: begin t = 3'd0; len = 16; end
         8'h45: begin t = 3'd1; len = 16; end
         8'h1C: begin t = 3'd2; len = 4;  end
         8'h7C: begin t = 3'd3; len = 4;  end
         8'hFC: begin t = 3'd4; len = 16; end
         8'h3C: begin t = 3'd5; len = 4;  end
         default: ok = 1'b0;
      endcase
   endtask

   task automatic dec1(input logic [7:0] b, output bit ok, output logic [2:0] t);
      ok = 1'b1; t = 3'd0;
      case (b)
         8'h1E: t = 3'd0;
         8'h2D: t = 3'd1;
         8'hAA: t = 3'd2;
         8'h66: t = 3'd3;
         8'h00: t = 3'd4;
         default: ok = 1'b0;
      endcase
   endtask

   function automatic ent_t make_ent(input logic [2:0] t, input int len, input int start);
      ent_t e;
      logic [LANES*8-1:0] w;
      e.t = t; e.len = 5'(len); e.d = '0;
      for (int s = 0; s < len; s++) begin
         w = strm[start+s];
         for (int l = 0; l < LANES; l++)
            if (l < int'(active_lanes)) e.d[l*128 + s*8 +: 8] = w[l*8 +: 8];
      end
      return e;
   endfunction

   // 8b/10b: scan the lane-0 symbol stream for COM-delimited sets
   task automatic model0();
      int n = strm.size();
      int i = 0, j, len;
      bit ok, cut;
      logic [2:0] t;
      logic [LANES*8-1:0] w;
      while (i < n) begin
         w = strm[i];
         if (w[7:0] != 8'hBC) begin i++; continue; end
         if (i + 1 >= n) break;
         w = strm[i+1];
         dec0(w[7:0], ok, t, len);
         if (!ok) begin err_exp++; i += 2; continue; end
         j = i + 2; cut = 1'b0;
         while (j < i + len && j < n) begin
            w = strm[j];
            if (len == 16 && t != 3'd4 && w[7:0] == 8'hBC) begin cut = 1'b1; break; end
            j++;
         end
         if (cut) begin err_exp++; i = j; continue; end
         if (j < i + len) break;
         exp_q.push_back(make_ent(t, len, i));
         i += len;
      end
   endtask

   // 128b/130b: one 16-symbol block per header
   task automatic model1();
      bit ok;
      logic [2:0] t;
      logic [LANES*8-1:0] w;
      for (int b = 0; b < hdr_q.size(); b++) begin
         w = strm[b*16];
         dec1(w[7:0], ok, t);
         if (hdr_q[b] == 2'b01) begin
            if (ok) exp_q.push_back(make_ent(t, 16, b*16));
            else err_exp++;
         end else if (hdr_q[b] != 2'b10) err_exp++;
      end
   endtask

   // ---------------- stimulus ----------------
   function automatic logic [LANES*8-1:0] word(input logic [7:0] b0);
      logic [LANES*8-1:0] w;
      for (int l = 0; l < LANES; l++) w[l*8 +: 8] = 8'($urandom_range(0, 255));
      w[7:0] = b0;
      return w;
   endfunction

   function automatic logic [7:0] nonbc();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == 8'hBC);
      return b;
   endfunction

   task automatic pad();
      while (strm.size() % SYMS != 0) strm.push_back(word(nonbc()));
   endtask

   task automatic gen0(input int nsets);
      logic [7:0] tl [6];
      logic [7:0] b1;
      logic [2:0] t;
      int len, np;
      bit ok, trunc;
      tl = '{8'h4A, 8'h45, 8'h1C, 8'h7C, 8'hFC, 8'h3C};
      trunc = 1'b0;
      for (int n = 0; n < nsets; n++) begin
         if (!trunc) repeat ($urandom_range(0, 3)) strm.push_back(word(nonbc()));
         strm.push_back(word(8'hBC));
         // a set right after a cut one always carries a valid type byte
         b1 = (trunc || $urandom_range(0, 9) != 0) ? tl[$urandom_range(0, 5)] : 8'h11;
         trunc = 1'b0;
         strm.push_back(word(b1));
         dec0(b1, ok, t, len);
         if (!ok) continue;
         np = len - 2;
         if (len == 16 && t != 3'd4 && n < nsets - 1 && $urandom_range(0, 5) == 0) begin
            np = $urandom_range(0, 10);
            trunc = 1'b1;
         end
         for (int p = 0; p < np; p++)
            strm.push_back(word((t == 3'd4 && $urandom_range(0, 3) == 0) ? 8'hBC : nonbc()));
      end
      repeat (3) strm.push_back(word(nonbc()));
      pad();
   endtask

   task automatic gen1(input int nb);
      logic [7:0] tl [5];
      int r;
      tl = '{8'h1E, 8'h2D, 8'hAA, 8'h66, 8'h00};
      for (int b = 0; b < nb; b++) begin
         r = $urandom_range(0, 9);
         hdr_q.push_back(r < 6 ? 2'b01 : r < 8 ? 2'b10 : r == 8 ? 2'b00 : 2'b11);
         strm.push_back(word($urandom_range(0, 7) == 0 ? 8'h55 : tl[$urandom_range(0, 4)]));
         repeat (15) strm.push_back(word(8'($urandom_range(0, 255))));
      end
   endtask

   task automatic feed();
      int idx = 0;
      logic [LANES*8-1:0] w;
      while (strm.size() >= SYMS) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) != 0) begin
            data_valid = 1'b1;
            if (mode) begin
               block_start = (idx % 16 == 0);
               sync_hdr = (idx % 16 == 0) ? hdr_q.pop_front() : 2'($urandom_range(0, 3));
            end else begin
               block_start = 1'($urandom_range(0, 1));
               sync_hdr = 2'($urandom_range(0, 3));
            end
            for (int k = 0; k < SYMS; k++) begin
               w = strm.pop_front();
               for (int l = 0; l < LANES; l++) data_in[(l*SYMS+k)*8 +: 8] = w[l*8 +: 8];
            end
            idx += SYMS;
         end else begin
            data_valid = 1'b0;
            block_start = 1'($urandom_range(0, 1));
            sync_hdr = 2'($urandom_range(0, 3));
            for (int i = 0; i < LANES*SYMS; i++) data_in[i*8 +: 8] = 8'($urandom_range(0, 255));
         end
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      block_start = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
      chk({nm, " drained"}, exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, " os_err count"}, err_seen, err_exp);
      chk({nm, " overflow count"}, ovf_seen, ovf_exp);
   endtask

   task automatic run(input string nm, input bit m1);
      if (m1) model1(); else model0();
      feed();
      drain(nm);
   endtask

   initial begin
      clk = 1'b0; reset = 1'b0; mode = 1'b0; active_lanes = 5'd4;
      data_in = '0; data_valid = 1'b0; block_start = 1'b0; sync_hdr = 2'b00; os_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset os_valid", os_valid, 0);
      chk("reset os_data", os_data, 0);
      chk("reset os_type", os_type, 0);
      chk("reset os_len", os_len, 0);
      chk("reset os_err", os_err, 0);
      chk("reset overflow", overflow, 0);
      reset = 1'b1;

      // TS1 across 8 cycles of two symbols
      strm.push_back(word(8'hBC)); strm.push_back(word(8'h4A));
      repeat (14) strm.push_back(word(nonbc()));
      run("ts1", 1'b0);

      // SKP then EIOS back to back
      strm.push_back(word(8'hBC)); repeat (3) strm.push_back(word(8'h1C));
      strm.push_back(word(8'hBC)); repeat (3) strm.push_back(word(8'h7C));
      run("skp eios", 1'b0);

      // TS1 cut short by a TS2
      strm.push_back(word(8'hBC)); strm.push_back(word(8'h4A));
      repeat (6) strm.push_back(word(nonbc()));
      strm.push_back(word(8'hBC)); strm.push_back(word(8'h45));
      repeat (14) strm.push_back(word(nonbc()));
      run("ts1 cut by ts2", 1'b0);

      for (int a = 0; a < 3; a++) begin
         active_lanes = 5'(4 >> a);
         gen0(30);
         run("random 8b10b", 1'b0);
      end

      mode = 1'b1;
      for (int a = 0; a < 2; a++) begin
         active_lanes = 5'(4 >> a);
         gen1(10);
         run("random 128b130b", 1'b1);
      end

      // five SKPs into a 4-deep FIFO with the consumer stalled
      mode = 1'b0; active_lanes = 5'd4; os_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         strm.push_back(word(8'hBC)); strm.push_back(word(8'h1C));
         strm.push_back(word(nonbc())); strm.push_back(word(nonbc()));
      end
      model0();
      void'(exp_q.pop_back());
      ovf_exp++;
      feed();
      repeat (4) @(posedge clk);
      #1;
      chk("overflow pulse count", ovf_seen, ovf_exp);
      chk("full os_valid", os_valid, 1);
      os_ready = 1'b1;
      drain("overflow");

      // reset in the middle of a TS1
      strm.push_back(word(8'hBC)); strm.push_back(word(8'h4A));
      repeat (6) strm.push_back(word(nonbc()));
      feed();
      reset = 1'b0;
      #1;
      chk("mid reset os_valid", os_valid, 0);
      chk("mid reset os_data", os_data, 0);
      chk("mid reset os_len", os_len, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (12) strm.push_back(word(nonbc()));
      feed();
      repeat (5) @(posedge clk);
      #1;
      chk("post reset os_valid", os_valid, 0);
      chk("post reset drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
